pmod_amp3_i2s_tx: RTL and testbench
===================================

PMOD_AMP3_I2S_TX -- requirements
Module: pmod_amp3_i2s_tx

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 16, sample bits per channel; legal range 8..24.
REQ-002 Parameter FIFO_DEPTH, default 4, stereo-pair FIFO entries; power of two, 2..16.
REQ-003 Parameter MCLK_HALF, default 2, clk cycles per MCLK half-period; minimum 1.
REQ-004 Parameter BCLK_RATIO, default 4, MCLK periods per SCLK period; even, minimum 2.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  high runs audio clocks and serialiser; low idles them.
REQ-008 mute  in  1  high forces transmitted samples to zero; FIFO still pops.
REQ-009 s_valid  in  1  stereo pair offered.
REQ-010 s_ready  out  1  FIFO can accept a pair.
REQ-011 s_left, s_right  in  SAMPLE_WIDTH each  two's-complement samples.
REQ-012 underrun  out  1  sticky; frame started with FIFO empty.
REQ-013 underrun_clr  in  1  clears underrun.
REQ-014 pin1_i..pin10_i (1-4, 7-10)  in  1 each  unused.
REQ-015 pin1_o..pin10_o  out  1 each  pmod outputs: 1=LRCK, 2=SDOUT, 4=SCLK, 9=MCLK, 10=amp shutdown-not; others 0.
REQ-016 pin1_t..pin10_t  out  1 each  tristate; 0 for pins 1,2,4,9,10; 1 for pins 3,7,8.

Function
REQ-017 FIFO: write when s_valid && s_ready; s_ready = not full; pop only at frame start (REQ-022); simultaneous write and pop when full is not possible (s_ready low); write and pop when empty: pop sees empty, write lands.
REQ-018 Divider counter cnt counts 0..P-1, P = 2*MCLK_HALF*BCLK_RATIO, wrapping; MCLK toggles every MCLK_HALF cycles starting low at cnt 0.
REQ-019 SCLK low for cnt 0..P/2-1, high for P/2..P-1; cnt = 0 is the SCLK falling boundary.
REQ-020 Bit counter bit_cnt 0..63 advances by one (wrapping 63->0) at each SCLK falling boundary.
REQ-021 LRCK = 0 for bit_cnt 0..31 (left slot), 1 for 32..63 (right slot).
REQ-022 At the boundary entering bit_cnt 0: if FIFO non-empty, pop head into frame register; else load zeros and set underrun.
REQ-023 SDOUT in slot position k = bit_cnt mod 32: k in 1..SAMPLE_WIDTH drives sample bit SAMPLE_WIDTH-k (MSB first, one-SCLK I2S delay); k = 0 and k > SAMPLE_WIDTH drive 0.
REQ-024 mute high at frame load substitutes zeros; mute changes mid-frame take effect at next frame.
REQ-025 All pin outputs registered; changes of LRCK/SDOUT/SCLK/MCLK occur on the same clk edge as their counter update.
REQ-026 enable low: cnt, bit_cnt held 0; MCLK, SCLK, LRCK, SDOUT held 0; pin10_o = 0; FIFO retains contents and accepts writes.
REQ-027 enable rising: pin10_o = 1 and counting starts the following cycle; the first cycle with enable high counts as a bit_cnt 0 boundary (REQ-022 applies).
REQ-028 enable falling mid-frame: frame aborted, popped pair discarded.
REQ-029 underrun_clr has priority over a same-cycle set; underrun remains 0 that cycle, sets on the next empty frame.

Reset
REQ-030 reset asserted: FIFO empty, cnt = 0, bit_cnt = 0, frame register 0, underrun = 0, s_ready = 0, all pin*_o = 0; pin*_t constant per REQ-016.
REQ-031 First clk edge after reset deassertion: s_ready = 1; reset mid-frame discards FIFO and frame immediately.

Verification
REQ-032 Defaults, enable=1, push pair left=16'hA5C3, right=16'h0001 -> SCLK period 16 clk, MCLK period 4 clk; left slot SDOUT bits 1..16 = 1010010111000011, right slot bit 16 = 1, all others 0.
REQ-033 Push 4 pairs with enable=0 -> s_ready low after 4th; 5th s_valid ignored; enable=1 -> 4 frames transmitted in order.
REQ-034 enable=1, FIFO empty -> underrun = 1 within first frame, SDOUT all 0; underrun_clr pulse -> 0; stays 0 after pushing data.
REQ-035 mute=1 with pair 16'h7FFF/16'h8000 queued -> frame SDOUT all 0, FIFO depth decrements by one.
REQ-036 SAMPLE_WIDTH=24, 24'h800001 -> MSB at slot position 1, LSB at position 24, positions 25..31 = 0.
REQ-037 reset pulse mid-frame -> all pin*_o 0 same cycle; s_ready 1 one cycle after deassertion; FIFO empty.

Source files
------------

// File: rtl/pmod_amp3_i2s_tx.sv
// I2S transmitter for the Digilent Pmod AMP3: stereo-pair FIFO, MCLK/SCLK/LRCK generation
// and a 64-bit-per-frame serialiser, all timed from a single system clock.
module pmod_amp3_i2s_tx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int MCLK_HALF    = 2,
    parameter int BCLK_RATIO   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    mute,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SAMPLE_WIDTH-1:0] s_left,
    input  logic [SAMPLE_WIDTH-1:0] s_right,
    output logic                    underrun,
    input  logic                    underrun_clr,
    input  logic                    pin1_i,
    input  logic                    pin2_i,
    input  logic                    pin3_i,
    input  logic                    pin4_i,
    input  logic                    pin7_i,
    input  logic                    pin8_i,
    input  logic                    pin9_i,
    input  logic                    pin10_i,
    output logic                    pin1_o,
    output logic                    pin2_o,
    output logic                    pin3_o,
    output logic                    pin4_o,
    output logic                    pin7_o,
    output logic                    pin8_o,
    output logic                    pin9_o,
    output logic                    pin10_o,
    output logic                    pin1_t,
    output logic                    pin2_t,
    output logic                    pin3_t,
    output logic                    pin4_t,
    output logic                    pin7_t,
    output logic                    pin8_t,
    output logic                    pin9_t,
    output logic                    pin10_t
);

    localparam int PERIOD  = 2 * MCLK_HALF * BCLK_RATIO;
    localparam int CNT_W   = $clog2(PERIOD);
    localparam int MDIV_W  = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int FRAME_W = 2 * SAMPLE_WIDTH;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(PERIOD / 2);
    localparam logic [MDIV_W-1:0] MDIV_LAST = MDIV_W'(MCLK_HALF - 1);
    localparam logic [AW:0]       FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [4:0]        SLOT_LAST = 5'(SAMPLE_WIDTH);

    logic [FRAME_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               s_ready_q, s_ready_d;
    logic               underrun_q, underrun_d;
    logic               run_q, run_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MDIV_W-1:0]  mdiv_q, mdiv_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               mclk_q, mclk_d;
    logic               sclk_q, sclk_d;
    logic               lrck_q, lrck_d;
    logic               sdout_q, sdout_d;

    logic                    push, pop, load;
    logic [4:0]              slot_pos;
    logic [SAMPLE_WIDTH-1:0] sample, shifted;

    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    always_comb begin
        push      = s_valid && s_ready_q;
        load      = 1'b0;
        run_d     = enable;
        cnt_d     = '0;
        mdiv_d    = '0;
        bit_cnt_d = '0;
        mclk_d    = 1'b0;
        frame_d   = frame_q;

        if (!enable) begin
            frame_d = '0;
        end else if (!run_q) begin
            // First enabled cycle holds the counters at zero and acts as a frame start.
            load = 1'b1;
        end else begin
            if (cnt_q == CNT_LAST) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                load      = (bit_cnt_q == 6'd63);
            end else begin
                cnt_d     = cnt_q + 1'b1;
                bit_cnt_d = bit_cnt_q;
            end
            if (cnt_d == '0) begin
                mdiv_d = '0;
                mclk_d = 1'b0;
            end else if (mdiv_q == MDIV_LAST) begin
                mdiv_d = '0;
                mclk_d = !mclk_q;
            end else begin
                mdiv_d = mdiv_q + 1'b1;
                mclk_d = mclk_q;
            end
        end

        pop        = load && (count_q != '0);
        underrun_d = underrun_q;
        if (load) begin
            if (pop) begin
                frame_d = mute ? '0 : fifo_mem_q[rd_ptr_q];
            end else begin
                frame_d    = '0;
                underrun_d = 1'b1;
            end
        end
        if (underrun_clr) begin
            underrun_d = 1'b0;
        end

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        s_ready_d = (count_d != FIFO_FULL);

        // Outputs are derived from the next counter values so they change on the same edge.
        sclk_d   = (cnt_d >= CNT_HALF);
        lrck_d   = bit_cnt_d[5];
        slot_pos = bit_cnt_d[4:0];
        sample   = bit_cnt_d[5] ? frame_d[SAMPLE_WIDTH-1:0] : frame_d[FRAME_W-1:SAMPLE_WIDTH];
        shifted  = sample << (slot_pos - 5'd1);
        sdout_d  = (slot_pos != 5'd0) && (slot_pos <= SLOT_LAST) && shifted[SAMPLE_WIDTH-1];
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            s_ready_q  <= 1'b0;
            underrun_q <= 1'b0;
            run_q      <= 1'b0;
            cnt_q      <= '0;
            mdiv_q     <= '0;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            mclk_q     <= 1'b0;
            sclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            sdout_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            s_ready_q  <= s_ready_d;
            underrun_q <= underrun_d;
            run_q      <= run_d;
            cnt_q      <= cnt_d;
            mdiv_q     <= mdiv_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            mclk_q     <= mclk_d;
            sclk_q     <= sclk_d;
            lrck_q     <= lrck_d;
            sdout_q    <= sdout_d;
        end
    end

    // NOTE: the sample storage has no reset; the cleared pointers and count make old contents unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {s_left, s_right};
        end
    end

    logic unused_pins;
    assign unused_pins = ^{pin1_i, pin2_i, pin3_i, pin4_i, pin7_i, pin8_i, pin9_i, pin10_i};

    assign s_ready  = s_ready_q;
    assign underrun = underrun_q;

    assign pin1_o  = lrck_q;
    assign pin2_o  = sdout_q;
    assign pin3_o  = 1'b0;
    assign pin4_o  = sclk_q;
    assign pin7_o  = 1'b0;
    assign pin8_o  = 1'b0;
    assign pin9_o  = mclk_q;
    assign pin10_o = run_q;

    assign pin1_t  = 1'b0;
    assign pin2_t  = 1'b0;
    assign pin3_t  = 1'b1;
    assign pin4_t  = 1'b0;
    assign pin7_t  = 1'b1;
    assign pin8_t  = 1'b1;
    assign pin9_t  = 1'b0;
    assign pin10_t = 1'b0;

endmodule

// File: tb/tb_pmod_amp3_i2s_tx.sv
// Directed bench for pmod_amp3_i2s_tx: default-parameter instance plus a 24-bit instance,
// with expected I2S frames and clock waveforms computed by hand from the pair values.
module tb_pmod_amp3_i2s_tx;

    localparam int P         = 16;
    localparam int FRAME_CYC = 64 * P;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0, mute = 1'b0, s_valid = 1'b0, underrun_clr = 1'b0;
    logic [15:0] s_left = '0, s_right = '0;
    logic s_ready, underrun;
    logic [7:0] pin_i = '0;
    wire  [7:0] po, pt;

    logic enable24 = 1'b0, s_valid24 = 1'b0, tie0 = 1'b0;
    logic [23:0] s_left24 = '0, s_right24 = '0;
    logic s_ready24, underrun24;
    wire  [7:0] o24, t24;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // po/pt bit order: [0]=pin1 [1]=pin2 [2]=pin3 [3]=pin4 [4]=pin7 [5]=pin8 [6]=pin9 [7]=pin10
    pmod_amp3_i2s_tx u_dut (
        .clk(clk), .reset(reset), .enable(enable), .mute(mute),
        .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
        .underrun(underrun), .underrun_clr(underrun_clr),
        .pin1_i(pin_i[0]), .pin2_i(pin_i[1]), .pin3_i(pin_i[2]), .pin4_i(pin_i[3]),
        .pin7_i(pin_i[4]), .pin8_i(pin_i[5]), .pin9_i(pin_i[6]), .pin10_i(pin_i[7]),
        .pin1_o(po[0]), .pin2_o(po[1]), .pin3_o(po[2]), .pin4_o(po[3]),
        .pin7_o(po[4]), .pin8_o(po[5]), .pin9_o(po[6]), .pin10_o(po[7]),
        .pin1_t(pt[0]), .pin2_t(pt[1]), .pin3_t(pt[2]), .pin4_t(pt[3]),
        .pin7_t(pt[4]), .pin8_t(pt[5]), .pin9_t(pt[6]), .pin10_t(pt[7])
    );

    pmod_amp3_i2s_tx #(.SAMPLE_WIDTH(24)) u_dut24 (
        .clk(clk), .reset(reset), .enable(enable24), .mute(tie0),
        .s_valid(s_valid24), .s_ready(s_ready24), .s_left(s_left24), .s_right(s_right24),
        .underrun(underrun24), .underrun_clr(tie0),
        .pin1_i(pin_i[0]), .pin2_i(pin_i[1]), .pin3_i(pin_i[2]), .pin4_i(pin_i[3]),
        .pin7_i(pin_i[4]), .pin8_i(pin_i[5]), .pin9_i(pin_i[6]), .pin10_i(pin_i[7]),
        .pin1_o(o24[0]), .pin2_o(o24[1]), .pin3_o(o24[2]), .pin4_o(o24[3]),
        .pin7_o(o24[4]), .pin8_o(o24[5]), .pin9_o(o24[6]), .pin10_o(o24[7]),
        .pin1_t(t24[0]), .pin2_t(t24[1]), .pin3_t(t24[2]), .pin4_t(t24[3]),
        .pin7_t(t24[4]), .pin8_t(t24[5]), .pin9_t(t24[6]), .pin10_t(t24[7])
    );

    // Expected SDOUT per bit slot: position k in 1..sw carries sample bit sw-k, MSB first.
    function automatic logic [63:0] exp_bits(input int sw, input logic [23:0] l, input logic [23:0] r);
        logic [63:0] v;
        logic [23:0] ls, rs;
        v  = '0;
        ls = l << (24 - sw);
        rs = r << (24 - sw);
        v[24:1]  = {<<{ls}};
        v[56:33] = {<<{rs}};
        return v;
    endfunction

    task automatic push16(input logic [15:0] l, input logic [15:0] r);
        @(negedge clk);
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic check_ready(input string name, input logic want);
        total++;
        if (s_ready !== want) begin
            bad++;
            $display("FAIL %s: s_ready=%b want %b", name, s_ready, want);
        end
    endtask

    task automatic check_underrun(input string name, input logic want);
        total++;
        if (underrun !== want) begin
            bad++;
            $display("FAIL %s: underrun=%b want %b", name, underrun, want);
        end
    endtask

    // Raises enable, then checks every cycle of nframes frames against the ideal waveform.
    task automatic run_frames(input int nframes, input string name);
        logic [63:0] cap, want;
        logic [31:0] pair;
        int wave_err;
        wave_err = 0;
        cap = '0;
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < nframes * FRAME_CYC; n++) begin
            int c, b;
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            c = n % P;
            b = (n / P) % 64;
            if (po !== {1'b1, 1'(((c / 2) % 2)), 2'b00, 1'(c >= 8), 1'b0, po[1], 1'(b >= 32)})
                wave_err++;
            if (c == 8) cap[b] = po[1];
            if (n % FRAME_CYC == FRAME_CYC - 1) begin
                pair = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
                want = exp_bits(16, {8'h00, pair[31:16]}, {8'h00, pair[15:0]});
                total++;
                if (cap !== want) begin
                    bad++;
                    $display("FAIL %s frame %0d sdout: got=%h want=%h", name, n / FRAME_CYC, cap, want);
                end
            end
        end
        total++;
        if (wave_err !== 0) begin
            bad++;
            $display("FAIL %s clocks: %0d cycles off MCLK/SCLK/LRCK/pin10 pattern, want 0", name, wave_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (po !== 8'h00) begin
            bad++;
            $display("FAIL reset_pins_o: got=%h want=00", po);
        end
        total++;
        if (pt !== 8'h34) begin
            bad++;
            $display("FAIL reset_pins_t: got=%h want=34", pt);
        end
        check_ready("reset_s_ready", 1'b0);
        check_underrun("reset_underrun", 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_ready("first_edge_s_ready", 1'b1);
    endtask

    task automatic test_single_frame();
        push16(16'hA5C3, 16'h0001);
        exp_q.push_back(32'hA5C3_0001);
        run_frames(1, "single");
        @(negedge clk);
        enable = 1'b0;
        check_underrun("single_no_underrun", 1'b0);
    endtask

    task automatic test_fifo_full();
        logic [31:0] pairs [4];
        pairs[0] = 32'h1234_FEDC;
        pairs[1] = 32'h8000_7FFF;
        pairs[2] = 32'h00FF_FF00;
        pairs[3] = 32'hC3A5_5A3C;
        for (int i = 0; i < 4; i++) begin
            push16(pairs[i][31:16], pairs[i][15:0]);
            exp_q.push_back(pairs[i]);
            check_ready("fill_s_ready", (i < 3));
        end
        push16(16'hDEAD, 16'hBEEF);
        check_ready("fifth_ignored_s_ready", 1'b0);
        run_frames(4, "fifo_order");
        @(negedge clk);
        enable = 1'b0;
        check_ready("drained_s_ready", 1'b1);
        check_underrun("fifo_no_underrun", 1'b0);
    endtask

    task automatic test_underrun();
        exp_q.push_back(32'h0);
        run_frames(1, "underrun_frame");
        check_underrun("underrun_set", 1'b1);
        @(negedge clk);
        enable = 1'b0;
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check_underrun("underrun_cleared", 1'b0);
        // Clear in the same cycle as an empty frame start wins; the next empty frame sets it.
        @(negedge clk);
        enable = 1'b1;
        underrun_clr = 1'b1;
        @(posedge clk);
        #1;
        check_underrun("clr_priority", 1'b0);
        @(negedge clk);
        underrun_clr = 1'b0;
        repeat (FRAME_CYC - 1) @(posedge clk);
        #1;
        check_underrun("before_next_frame", 1'b0);
        @(posedge clk);
        #1;
        check_underrun("next_empty_frame", 1'b1);
        @(negedge clk);
        enable = 1'b0;
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        push16(16'h7FFF, 16'h8000);
        repeat (20) @(negedge clk);
        check_underrun("stays_clear_after_push", 1'b0);
    endtask

    task automatic test_mute();
        push16(16'h1357, 16'h2468);
        push16(16'hF00F, 16'h0FF0);
        push16(16'h0101, 16'h8080);
        check_ready("mute_fifo_full", 1'b0);
        mute = 1'b1;
        exp_q.push_back(32'h0);
        run_frames(1, "mute_frame");
        @(negedge clk);
        enable = 1'b0;
        mute = 1'b0;
        check_underrun("mute_not_underrun", 1'b0);
        check_ready("mute_popped_one", 1'b1);
        push16(16'hABCD, 16'h4321);
        check_ready("mute_refilled", 1'b0);
        exp_q.push_back(32'h1357_2468);
        exp_q.push_back(32'hF00F_0FF0);
        exp_q.push_back(32'h0101_8080);
        exp_q.push_back(32'hABCD_4321);
        run_frames(4, "after_mute");
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic test_width24();
        logic [63:0] cap, want;
        cap = '0;
        @(negedge clk);
        s_valid24 = 1'b1;
        s_left24  = 24'h800001;
        s_right24 = 24'h5A5A5A;
        @(negedge clk);
        s_valid24 = 1'b0;
        enable24  = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < FRAME_CYC; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (n % P == 8) cap[n / P] = o24[1];
        end
        @(negedge clk);
        enable24 = 1'b0;
        want = exp_bits(24, 24'h800001, 24'h5A5A5A);
        total++;
        if (cap !== want) begin
            bad++;
            $display("FAIL w24 frame: got=%h want=%h", cap, want);
        end
        total++;
        if ({cap[31:24], cap[1], cap[0]} !== 10'b0000000_1_1_0) begin
            bad++;
            $display("FAIL w24 edges: pos31..24=%b pos1=%b pos0=%b want 00000001 1 0",
                     cap[31:24], cap[1], cap[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        push16(16'h1111, 16'h2222);
        push16(16'h3333, 16'h4444);
        push16(16'h5555, 16'h6666);
        @(negedge clk);
        enable = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        total++;
        if (po[7] !== 1'b1) begin
            bad++;
            $display("FAIL mid_frame_running: pin10_o=%b want 1", po[7]);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (po !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset_pins_o: got=%h want=00", po);
        end
        check_ready("mid_reset_s_ready", 1'b0);
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_ready("after_mid_reset_s_ready", 1'b1);
        for (int i = 0; i < 4; i++) begin
            push16(16'(i), 16'(i + 8));
            check_ready("refill_after_reset", (i < 3));
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_frame();
        test_fifo_full();
        test_underrun();
        test_mute();
        test_width24();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
